// File: rtl/iot_pkg.sv
// rtl/iot_pkg.sv - shared types and defaults for the IoT event scheduler
package iot_pkg;

   localparam int IOT_N_DEV_DEFAULT = 8;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HOLD = 2'd1,
      CLR  = 2'd2
   } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker over a request vector
module rr_pick #(
   parameter int N_DEV = 8,
   parameter int IDW   = $clog2(N_DEV)
) (
   input  logic [N_DEV-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic             found,
   output logic [IDW-1:0]   idx
);

   logic [2*N_DEV-1:0] dbl;
   int                 first;

   // Two copies of req: bits below ptr are masked in the low copy only, so the
   // lowest surviving bit is the first request at or after ptr with wrap.
   always_comb begin
      dbl = {req, req};
      for (int j = 0; j < N_DEV; j++) begin
         if (j < int'(ptr)) dbl[j] = 1'b0;
      end
      first = 0;
      for (int j = 2*N_DEV-1; j >= 0; j--) begin
         if (dbl[j]) first = j;
      end
      found = |req;
      idx   = (first >= N_DEV) ? IDW'(first - N_DEV) : IDW'(first);
   end

endmodule

// File: rtl/iot_event_sched.sv
// rtl/iot_event_sched.sv - serialises device on/off changes into monitor up/down commands
module iot_event_sched
   import iot_pkg::*;
#(
   parameter int N_DEV = IOT_N_DEV_DEFAULT,
   parameter int IDW   = $clog2(N_DEV)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_DEV-1:0] dev_status,
   input  logic             enable,
   input  logic             clear,
   output logic             change,
   output logic             on_off,
   output logic             mon_clr,
   output logic [IDW-1:0]   grant_id,
   output logic [N_DEV-1:0] reported,
   output logic [N_DEV-1:0] pending,
   output logic             busy
);

   logic [N_DEV-1:0] status_q;
   logic [N_DEV-1:0] reported_q;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   ptr_d;
   sched_state_t     state_q;
   logic             change_q;
   logic             on_off_q;
   logic             mon_clr_q;
   logic [IDW-1:0]   grant_id_q;
   logic             pick_found;
   logic [IDW-1:0]   pick_idx;

   assign pending  = status_q ^ reported_q;
   assign busy     = (|pending) || (state_q != RUN);
   assign reported = reported_q;
   assign change   = change_q;
   assign on_off   = on_off_q;
   assign mon_clr  = mon_clr_q;
   assign grant_id = grant_id_q;

   rr_pick #(.N_DEV(N_DEV), .IDW(IDW)) u_pick (
      .req   (pending),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Pointer moves just past the served device so it gets lowest priority next.
   always_comb begin
      ptr_d = (pick_idx == IDW'(N_DEV-1)) ? '0 : pick_idx + 1'b1;
   end

   // Capture device levels once per cycle; everything downstream uses this copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) status_q <= '0;
      else     status_q <= dev_status;
   end

   // Scheduler FSM: clear wins over issue; only RUN with enable high serves a device.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         reported_q <= '0;
         ptr_q      <= '0;
         change_q   <= 1'b0;
         on_off_q   <= 1'b0;
         mon_clr_q  <= 1'b0;
         grant_id_q <= '0;
      end else begin
         change_q  <= 1'b0;
         on_off_q  <= 1'b0;
         mon_clr_q <= 1'b0;
         if (clear) begin
            state_q    <= CLR;
            mon_clr_q  <= 1'b1;
            reported_q <= '0;
            ptr_q      <= '0;
         end else begin
            case (state_q)
               RUN: begin
                  if (!enable) begin
                     state_q <= HOLD;
                  end else if (pick_found) begin
                     change_q             <= 1'b1;
                     on_off_q             <= status_q[pick_idx];
                     grant_id_q           <= pick_idx;
                     reported_q[pick_idx] <= status_q[pick_idx];
                     ptr_q                <= ptr_d;
                  end
               end
               HOLD: begin
                  if (enable) state_q <= RUN;
               end
               CLR: begin
                  state_q <= enable ? RUN : HOLD;
               end
               default: state_q <= RUN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iot_event_sched.sv
// tb/tb_iot_event_sched.sv - scoreboard bench for iot_event_sched
module tb_iot_event_sched;

   localparam int N      = 8;
   localparam int M_RUN  = 0;
   localparam int M_HOLD = 1;
   localparam int M_CLR  = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] dev_status = '0;
   logic         enable = 1'b0;
   logic         clear = 1'b0;
   logic         change;
   logic         on_off;
   logic         mon_clr;
   logic [2:0]   grant_id;
   logic [N-1:0] reported;
   logic [N-1:0] pending;
   logic         busy;

   iot_event_sched #(.N_DEV(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .dev_status (dev_status),
      .enable     (enable),
      .clear      (clear),
      .change     (change),
      .on_off     (on_off),
      .mon_clr    (mon_clr),
      .grant_id   (grant_id),
      .reported   (reported),
      .pending    (pending),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   bit [N-1:0] m_st;
   bit [N-1:0] m_rep;
   int         m_ptr;
   int         m_mode;
   int         exp_q[$];
   int         log_q[$];
   int         want[$];
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cmp_log(input string name);
      chk({name, "_count"}, log_q.size(), want.size());
      for (int i = 0; i < log_q.size() && i < want.size(); i++)
         chk(name, log_q[i], want[i]);
   endtask

   // Reference: each edge serves the first device differing from its reported
   // state, searching from just after the last one served; events: -1 = clear,
   // otherwise on*16 + device.
   always @(posedge clk or posedge rst) begin
      bit [N-1:0] pend;
      bit         hit;
      int         i;
      if (rst) begin
         m_st = '0; m_rep = '0; m_ptr = 0; m_mode = M_RUN;
         exp_q.delete();
      end else begin
         pend = m_st ^ m_rep;
         if (clear) begin
            exp_q.push_back(-1);
            m_rep = '0; m_ptr = 0; m_mode = M_CLR;
         end else if (m_mode == M_RUN) begin
            if (!enable) m_mode = M_HOLD;
            else begin
               hit = 1'b0;
               for (int k = 0; k < N; k++) begin
                  i = (m_ptr + k) % N;
                  if (!hit && pend[i]) begin
                     hit = 1'b1;
                     exp_q.push_back(int'(m_st[i]) * 16 + i);
                     m_rep[i] = m_st[i];
                     m_ptr = (i + 1) % N;
                  end
               end
            end
         end else if (m_mode == M_HOLD) begin
            if (enable) m_mode = M_RUN;
         end else begin
            m_mode = enable ? M_RUN : M_HOLD;
         end
         m_st = dev_status;
      end
   end

   // Monitor: pop one expected event per observed command; track steady outputs.
   always @(negedge clk) begin
      int got;
      if (!rst) begin
         if (change || mon_clr) begin
            got = mon_clr ? -1 : int'(on_off) * 16 + int'(grant_id);
            if (change && mon_clr) chk("both_strobes", 1, 0);
            if (exp_q.size() == 0) chk("unexpected_event", got, -99);
            else chk("event", got, exp_q.pop_front());
            log_q.push_back(got);
         end else begin
            if (on_off) chk("on_off_idle", int'(on_off), 0);
         end
         chk("reported", int'(reported), int'(m_rep));
         chk("pending", int'(pending), int'(m_st ^ m_rep));
         chk("busy", int'(busy), int'((m_st != m_rep) || (m_mode != M_RUN)));
      end
   end

   initial begin
      cyc(2);
      chk("rst_change", int'(change), 0);
      chk("rst_on_off", int'(on_off), 0);
      chk("rst_mon_clr", int'(mon_clr), 0);
      chk("rst_grant", int'(grant_id), 0);
      chk("rst_reported", int'(reported), 0);
      rst = 1'b0;

      enable = 1'b1;
      log_q.delete();
      cyc(10);
      want = {};
      cmp_log("idle");
      chk("idle_busy", int'(busy), 0);

      log_q.delete();
      dev_status = 8'hFF;
      cyc(12);
      want = {16, 17, 18, 19, 20, 21, 22, 23};
      cmp_log("all_on");
      chk("all_on_reported", int'(reported), 8'hFF);
      chk("all_on_busy", int'(busy), 0);

      dev_status = 8'h00;
      cyc(12);
      enable = 1'b0;
      cyc(2);
      log_q.delete();
      dev_status = 8'h08;
      cyc(1);
      dev_status = 8'h00;
      cyc(3);
      enable = 1'b1;
      cyc(5);
      want = {};
      cmp_log("cancel");

      dev_status = 8'h0F;
      cyc(8);
      dev_status = 8'h0D;
      cyc(4);
      dev_status = 8'h0F;
      cyc(4);
      log_q.delete();
      dev_status = 8'h06;
      cyc(6);
      want = {3, 0};
      cmp_log("wrap_order");

      dev_status = 8'h05;
      cyc(6);
      log_q.delete();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      cyc(6);
      want = {-1, 16, 18};
      cmp_log("clear_recount");
      chk("clear_reported", int'(reported), 8'h05);

      dev_status = 8'h00;
      cyc(6);
      enable = 1'b0;
      dev_status = 8'hF0;
      cyc(3);
      #2 rst = 1'b1;
      #1;
      chk("arst_change", int'(change), 0);
      chk("arst_on_off", int'(on_off), 0);
      chk("arst_mon_clr", int'(mon_clr), 0);
      chk("arst_grant", int'(grant_id), 0);
      chk("arst_reported", int'(reported), 0);
      cyc(2);
      rst = 1'b0;
      log_q.delete();
      enable = 1'b1;
      cyc(8);
      want = {20, 21, 22, 23};
      cmp_log("post_reset");

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         dev_status = dev_status ^ N'($urandom & $urandom & $urandom);
         enable = ($urandom_range(0, 9) != 0);
         clear = ($urandom_range(0, 39) == 0);
         rst = ($urandom_range(0, 499) == 0);
      end
      @(negedge clk);
      rst = 1'b0;
      clear = 1'b0;
      enable = 1'b1;
      cyc(40);
      chk("drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
